// File: rtl/stopwatch_axil_master.sv
// stopwatch_axil_master: single-outstanding AXI4-Lite master driven by a simple command/response port.
// Define STOPWATCH_AXIM_WSTRB_EN to forward cmd_wstrb onto M_AXI_WSTRB; otherwise all byte lanes are written.
module stopwatch_axil_master #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_wstrb,
  output logic          rsp_valid,
  output logic          rsp_write,
  output logic [31:0]   rsp_rdata,
  output logic [1:0]    rsp_resp,
  output logic [AW-1:0] M_AXI_AWADDR,
  output logic          M_AXI_AWVALID,
  output logic [2:0]    M_AXI_AWPROT,
  input  logic          M_AXI_AWREADY,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  output logic [2:0]    M_AXI_ARPROT,
  input  logic          M_AXI_ARREADY,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;
  state_t r_state, w_next;
  logic w_accept, w_aw_done, w_w_done, w_unused;
  assign w_accept = cmd_ready && cmd_valid;
  // a channel whose VALID already dropped has completed its handshake
  assign w_aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_w_done = !M_AXI_WVALID || M_AXI_WREADY;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign w_unused = ^{cmd_wstrb, cmd_addr[1:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (cmd_write ? WRITE : READ) : IDLE;
      WRITE:   w_next = (w_aw_done && w_w_done) ? WRESP : WRITE;
      WRESP:   w_next = M_AXI_BVALID ? DONE : WRESP;
      READ:    w_next = M_AXI_ARREADY ? RDATA : READ;
      RDATA:   w_next = M_AXI_RVALID ? DONE : RDATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      M_AXI_AWADDR <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA <= '0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARADDR <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
`ifdef STOPWATCH_AXIM_WSTRB_EN
      M_AXI_WSTRB <= '0;
`endif
    end else begin
      r_state <= w_next;
      cmd_ready <= w_next == IDLE;
      rsp_valid <= w_next == DONE;
      M_AXI_BREADY <= w_next == WRESP;
      M_AXI_RREADY <= w_next == RDATA;
      M_AXI_ARVALID <= w_next == READ;
      M_AXI_AWVALID <= (w_accept && cmd_write) || (M_AXI_AWVALID && !M_AXI_AWREADY);
      M_AXI_WVALID <= (w_accept && cmd_write) || (M_AXI_WVALID && !M_AXI_WREADY);
      if (w_accept) begin
        M_AXI_AWADDR <= {cmd_addr[AW-1:2], 2'b00};
        M_AXI_ARADDR <= {cmd_addr[AW-1:2], 2'b00};
        M_AXI_WDATA <= cmd_wdata;
`ifdef STOPWATCH_AXIM_WSTRB_EN
        M_AXI_WSTRB <= cmd_wstrb;
`endif
      end
      if (r_state == WRESP && M_AXI_BVALID) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp <= M_AXI_BRESP;
      end
      if (r_state == RDATA && M_AXI_RVALID) begin
        rsp_write <= 1'b0;
        rsp_rdata <= M_AXI_RDATA;
        rsp_resp <= M_AXI_RRESP;
      end
    end
  end
`ifndef STOPWATCH_AXIM_WSTRB_EN
  assign M_AXI_WSTRB = 4'hF;
`endif
endmodule

// File: doc/stopwatch_axil_master.md
# stopwatch_axil_master

AXI4-Lite master that turns single-beat register commands from on-chip user logic into AXI4-Lite read and write transactions. It sits opposite the stopwatch register block (test value at 0x04, control at 0x08) and lets local logic, such as a self-test sequencer or a button handler, program and read back those registers without a processor. Exactly one transaction is in flight at a time. Each command produces exactly one response.

## Interface
- AW, 7, address bus width in bits; must match the slave's address width.
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AW  byte address; bits [1:0] ignored
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  byte strobes; used only with STOPWATCH_AXIM_WSTRB_EN
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_write  out  1  echoes cmd_write of the completed command
- rsp_rdata  out  32  read data; 0 after a write
- rsp_resp  out  2  BRESP or RRESP as returned by the slave
- M_AXI_AWADDR/AWVALID/AWPROT (out), AWREADY (in): AW channel
- M_AXI_WDATA/WSTRB/WVALID (out), WREADY (in): W channel
- M_AXI_BRESP/BVALID (in), BREADY (out): B channel
- M_AXI_ARADDR/ARVALID/ARPROT (out), ARREADY (in): AR channel
- M_AXI_RDATA/RRESP/RVALID (in), RREADY (out): R channel

## Operation
- States: IDLE, WRITE, WRESP, READ, RDATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, data and strobe.
  - Go to WRITE if cmd_write, else READ.
- WRITE:
  - AWVALID and WVALID rise together.
  - Each drops on the edge after its own handshake; the two are independent and may complete in either order or together.
  - Go to WRESP once both handshakes have completed.
- WRESP: BREADY=1; on BVALID, capture BRESP and set rsp_rdata=0, then go to DONE.
- READ: ARVALID=1 until ARREADY, then go to RDATA.
- RDATA: RREADY=1; on RVALID, capture RDATA and RRESP, then go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Address and protection:
  - AWADDR and ARADDR carry {cmd_addr[AW-1:2], 2'b00}.
  - AWPROT and ARPROT are 3'b000.
- Valid/ready rules:
  - VALID signals never depend combinationally on READY.
  - Once raised, a VALID and its payload hold stable until the handshake.
- cmd_valid outside IDLE is ignored; there is no queuing.
- SLVERR and DECERR are passed through on rsp_resp and do not change the FSM flow.

## Timing
- All outputs are registered.
- Reset values:
  - all VALID/READY outputs 0
  - cmd_ready 0 during reset, 1 the cycle after
  - rsp_valid 0, rsp_write 0, rsp_rdata 0, rsp_resp 0
  - M_AXI address and data buses 0
  - state IDLE
- Command accepted at edge N: AWVALID/WVALID or ARVALID are high from N+1.
- Slave with zero-wait READY/VALID:
  - write: AW/W handshake at N+1, BVALID seen at N+2, rsp_valid at N+3, cmd_ready again at N+4
  - read: same latency
- Reset mid-transaction: next edge returns all outputs to reset values and the FSM to IDLE, with no rsp_valid. The slave shares the same reset.
- No timeout: a slave that never responds holds the FSM indefinitely.

## Configuration
- STOPWATCH_AXIM_WSTRB_EN defined: M_AXI_WSTRB = latched cmd_wstrb. A write with cmd_wstrb=4'h0 is still issued.
- Not defined: M_AXI_WSTRB is tied to 4'hF, and cmd_wstrb is unused but stays on the port list.

## Test plan
- Write 0x04 = 0x12345678, then read 0x04 → rsp_resp=0 both times, read rsp_rdata=0x12345678, and rsp_valid exactly 3 cycles after each accept against a zero-wait slave.
- Read 0x0C from the stopwatch register block → rsp_resp=2'b11 (DECERR), rsp_valid one cycle, FSM back in IDLE.
- Write with AWREADY delayed 3 cycles and WREADY immediate → WVALID high 1 cycle, AWVALID high 4 cycles, BREADY only after both handshakes, and one rsp_valid.
- cmd_valid held high for 10 cycles during a read with RVALID delayed 5 cycles → exactly one AR transaction and one rsp_valid; the second command is accepted only after DONE.
- Reset asserted while in RDATA → next cycle RREADY=0, rsp_valid=0, cmd_ready=1 after reset releases; a following write of 0x1 to 0x08 completes OKAY.
- With STOPWATCH_AXIM_WSTRB_EN defined, write 0xAABBCCDD with strobe 4'h3 → M_AXI_WSTRB=4'h3. Without the macro → M_AXI_WSTRB=4'hF.
